// File: rtl/signal_generator_nch.sv
// Multi-channel DAC waveform generator: per-lane phase accumulator, waveform select,
// amplitude scaling, offset and saturation, with double-buffered configuration.
module signal_generator_nch #(
    parameter int NUM_CHANNELS    = 2,
    parameter int PHASE_WIDTH     = 32,
    parameter int SAMPLE_WIDTH    = 16,
    parameter int AMPLITUDE_WIDTH = 16,
    parameter int DAC_WIDTH       = 14
) (
    input  logic                                    clk,
    input  logic                                    aresetn,
    input  logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0]    s_axis_tdata_sine,
    input  logic [NUM_CHANNELS-1:0]                 s_axis_tvalid_sine,
    input  logic [NUM_CHANNELS*PHASE_WIDTH-1:0]     phase_inc,
    input  logic [NUM_CHANNELS*AMPLITUDE_WIDTH-1:0] amplitude,
    input  logic [NUM_CHANNELS*DAC_WIDTH-1:0]       offset,
    input  logic [NUM_CHANNELS*4-1:0]               cfg_mode,
    input  logic                                    cfg_update,
    input  logic                                    sync_reset,
    output logic [NUM_CHANNELS*16-1:0]              m_axis_tdata,
    output logic                                    m_axis_tvalid,
    output logic [NUM_CHANNELS-1:0]                 clip
);
    localparam int NC     = NUM_CHANNELS;
    localparam int PW     = PHASE_WIDTH;
    localparam int SW     = SAMPLE_WIDTH;
    localparam int AW     = AMPLITUDE_WIDTH;
    localparam int DW     = DAC_WIDTH;
    localparam int SHIFT  = AW + SW - DW;
    localparam int PROD_W = SW + AW + 1;
    localparam int SUM_W  = DW + 1;

    localparam logic [SW-1:0]        FS_U    = {1'b0, {(SW-1){1'b1}}};
    localparam logic signed [SW-1:0] RAW_MAX = {1'b0, {(SW-1){1'b1}}};
    localparam logic signed [SW-1:0] RAW_MIN = {1'b1, {(SW-1){1'b0}}};
    localparam logic signed [DW-1:0] DAC_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] DAC_MIN = {1'b1, {(DW-1){1'b0}}};

    // Active (committed) configuration
    logic [PW-1:0]        inc_q  [NC];
    logic [PW-1:0]        inc_d  [NC];
    logic [AW-1:0]        amp_q  [NC];
    logic [AW-1:0]        amp_d  [NC];
    logic signed [DW-1:0] off_q  [NC];
    logic signed [DW-1:0] off_d  [NC];
    logic [3:0]           mode_q [NC];
    logic [3:0]           mode_d [NC];

    logic [PW-1:0]            phase_q   [NC];
    logic [PW-1:0]            phase_d   [NC];
    logic signed [SW-1:0]     hold_q    [NC];
    logic signed [SW-1:0]     hold_d    [NC];
    logic signed [SW-1:0]     sine_cur  [NC];
    logic signed [SW-1:0]     raw_p1_q  [NC];
    logic signed [SW-1:0]     raw_p1_d  [NC];
    logic signed [PROD_W-1:0] prod_p2_q [NC];
    logic signed [PROD_W-1:0] prod_p2_d [NC];
    logic signed [SUM_W-1:0]  sum_p3    [NC];
    logic signed [DW-1:0]     out_p3_q  [NC];
    logic signed [DW-1:0]     out_p3_d  [NC];
    logic [NC-1:0]            clip_q;
    logic [NC-1:0]            clip_d;
    logic                     vld_p1_q, vld_p1_d;
    logic                     vld_p2_q, vld_p2_d;
    logic                     vld_p3_q, vld_p3_d;

    // ph_top holds the phase MSB and the SW bits beneath it.
    function automatic logic signed [SW-1:0] wave_raw(
        input logic [2:0]           kind,
        input logic [SW:0]          ph_top,
        input logic signed [SW-1:0] sine
    );
        logic [SW-1:0] u;
        logic [SW-1:0] top;
        u   = ph_top[SW-1:0];
        top = ph_top[SW:1];
        case (kind)
            3'd0:    wave_raw = sine;
            3'd1:    wave_raw = RAW_MAX;
            3'd2:    wave_raw = ph_top[SW] ? RAW_MIN : RAW_MAX;
            3'd3:    wave_raw = ph_top[SW] ? $signed(FS_U - u) : $signed({~u[SW-1], u[SW-2:0]});
            3'd4:    wave_raw = $signed({~top[SW-1], top[SW-2:0]});
            default: wave_raw = '0;
        endcase
    endfunction

    function automatic logic sum_overflows(input logic signed [SUM_W-1:0] v);
        sum_overflows = (v[SUM_W-1] != v[SUM_W-2]);
    endfunction

    function automatic logic signed [DW-1:0] sat_dac(input logic signed [SUM_W-1:0] v);
        if (v[SUM_W-1] == v[SUM_W-2])
            sat_dac = v[DW-1:0];
        else
            sat_dac = v[SUM_W-1] ? DAC_MIN : DAC_MAX;
    endfunction

    always_comb begin
        vld_p1_d = 1'b1;
        vld_p2_d = vld_p1_q;
        vld_p3_d = vld_p2_q;
        clip_d   = clip_q;
        for (int c = 0; c < NC; c++) begin
            inc_d[c]  = inc_q[c];
            amp_d[c]  = amp_q[c];
            off_d[c]  = off_q[c];
            mode_d[c] = mode_q[c];
            if (cfg_update) begin
                inc_d[c]  = phase_inc[c*PW +: PW];
                amp_d[c]  = amplitude[c*AW +: AW];
                off_d[c]  = $signed(offset[c*DW +: DW]);
                mode_d[c] = cfg_mode[c*4 +: 4];
            end

            // A disabled lane parks at 0, so re-enabling always restarts from phase 0.
            phase_d[c] = (sync_reset || !mode_q[c][3]) ? '0 : phase_q[c] + inc_q[c];

            sine_cur[c] = s_axis_tvalid_sine[c] ? $signed(s_axis_tdata_sine[c*SW +: SW]) : hold_q[c];
            hold_d[c]   = sine_cur[c];

            // S1: raw waveform
            raw_p1_d[c] = wave_raw(mode_q[c][2:0], phase_q[c][PW-1 -: SW+1], sine_cur[c]);

            // S2: amplitude product
            prod_p2_d[c] = PROD_W'(raw_p1_q[c]) * PROD_W'($signed({1'b0, amp_q[c]}));

            // S3: floor-shift, offset, saturate; the scaled value always fits DW bits
            sum_p3[c]   = SUM_W'(prod_p2_q[c] >>> SHIFT) + SUM_W'(off_q[c]);
            out_p3_d[c] = mode_q[c][3] ? sat_dac(sum_p3[c]) : '0;
            clip_d[c]   = (clip_q[c] & ~cfg_update) | (mode_q[c][3] & sum_overflows(sum_p3[c]));
        end
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            for (int c = 0; c < NC; c++) begin
                inc_q[c]     <= '0;
                amp_q[c]     <= '0;
                off_q[c]     <= '0;
                mode_q[c]    <= '0;
                phase_q[c]   <= '0;
                hold_q[c]    <= '0;
                raw_p1_q[c]  <= '0;
                prod_p2_q[c] <= '0;
                out_p3_q[c]  <= '0;
            end
            clip_q   <= '0;
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            vld_p3_q <= 1'b0;
        end else begin
            for (int c = 0; c < NC; c++) begin
                inc_q[c]     <= inc_d[c];
                amp_q[c]     <= amp_d[c];
                off_q[c]     <= off_d[c];
                mode_q[c]    <= mode_d[c];
                phase_q[c]   <= phase_d[c];
                hold_q[c]    <= hold_d[c];
                raw_p1_q[c]  <= raw_p1_d[c];
                prod_p2_q[c] <= prod_p2_d[c];
                out_p3_q[c]  <= out_p3_d[c];
            end
            clip_q   <= clip_d;
            vld_p1_q <= vld_p1_d;
            vld_p2_q <= vld_p2_d;
            vld_p3_q <= vld_p3_d;
        end
    end

    always_comb begin
        m_axis_tdata = '0;
        for (int c = 0; c < NC; c++)
            m_axis_tdata[c*16 +: 16] = 16'(out_p3_q[c]);
    end

    assign m_axis_tvalid = vld_p3_q;
    assign clip          = clip_q;

endmodule

// File: tb/tb_signal_generator_nch.sv
// Bench for signal_generator_nch: directed waveform scenarios plus randomized traffic
// against an arithmetic reference model of the generator.
module tb_signal_generator_nch;
    localparam int NC = 2;
    localparam int PW = 32;
    localparam int SW = 16;
    localparam int AW = 16;
    localparam int DW = 14;

    logic              clk = 1'b0;
    logic              aresetn;
    logic [NC*SW-1:0]  s_data;
    logic [NC-1:0]     s_valid;
    logic [NC*PW-1:0]  phase_inc;
    logic [NC*AW-1:0]  amplitude;
    logic [NC*DW-1:0]  offset;
    logic [NC*4-1:0]   cfg_mode;
    logic              cfg_update;
    logic              sync_reset;
    logic [NC*16-1:0]  m_axis_tdata;
    logic              m_axis_tvalid;
    logic [NC-1:0]     clip;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state, as visible after the most recent edge
    bit [31:0] m_inc [NC];
    int        m_amp [NC];
    int        m_off [NC];
    bit [3:0]  m_mode[NC];
    bit [31:0] m_ph  [NC];
    int        m_hold[NC];
    int        m_r1  [NC];
    int        m_s2  [NC];
    int        m_o3  [NC];
    bit        m_clip[NC];
    int        m_vcnt;

    always #5 clk = ~clk;

    signal_generator_nch #(
        .NUM_CHANNELS(NC), .PHASE_WIDTH(PW), .SAMPLE_WIDTH(SW),
        .AMPLITUDE_WIDTH(AW), .DAC_WIDTH(DW)
    ) dut (
        .clk(clk), .aresetn(aresetn),
        .s_axis_tdata_sine(s_data), .s_axis_tvalid_sine(s_valid),
        .phase_inc(phase_inc), .amplitude(amplitude), .offset(offset),
        .cfg_mode(cfg_mode), .cfg_update(cfg_update), .sync_reset(sync_reset),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .clip(clip)
    );

    function automatic int lane_out(input int c);
        return int'($signed(m_axis_tdata[c*16 +: 16]));
    endfunction

    // Raw waveform value straight from the waveform definitions, in plain integers.
    function automatic int raw_of(input int kind, input bit [31:0] ph, input int sine);
        int m, u, top;
        m   = int'(ph[31]);
        u   = int'(ph[30:15]);
        top = int'(ph[31:16]);
        case (kind)
            0: return sine;
            1: return 32767;
            2: return (m == 1) ? -32768 : 32767;
            3: return (m == 1) ? (32767 - u) : (u - 32768);
            4: return top - 32768;
            default: return 0;
        endcase
    endfunction

    function automatic int scale_of(input int raw, input int amp);
        return int'((longint'(raw) * longint'(amp)) >>> 18);
    endfunction

    task automatic set_lane(input int c, input logic [31:0] inc, input logic [15:0] amp,
                            input logic [13:0] off, input logic [3:0] mode);
        phase_inc[c*PW +: PW] = inc;
        amplitude[c*AW +: AW] = amp;
        offset[c*DW +: DW]    = off;
        cfg_mode[c*4 +: 4]    = mode;
    endtask

    // Advance one clock: model computes next state from current inputs, then the edge.
    task automatic tick();
        bit [31:0] n_inc[NC], n_ph[NC];
        bit [3:0]  n_mode[NC];
        int        n_amp[NC], n_off[NC], n_hold[NC], n_r1[NC], n_s2[NC], n_o3[NC];
        bit        n_clip[NC];
        int        n_vcnt, sc, sum;
        bit        en, sat;
        for (int c = 0; c < NC; c++) begin
            if (!aresetn) begin
                n_inc[c] = 0; n_amp[c] = 0; n_off[c] = 0; n_mode[c] = 0; n_ph[c] = 0;
                n_hold[c] = 0; n_r1[c] = 0; n_s2[c] = 0; n_o3[c] = 0; n_clip[c] = 0;
            end else begin
                sc        = s_valid[c] ? int'($signed(s_data[c*SW +: SW])) : m_hold[c];
                n_hold[c] = sc;
                n_r1[c]   = raw_of(int'(m_mode[c][2:0]), m_ph[c], sc);
                n_s2[c]   = scale_of(m_r1[c], m_amp[c]);
                en        = m_mode[c][3];
                sum       = m_s2[c] + m_off[c];
                sat       = en && (sum > 8191 || sum < -8192);
                n_o3[c]   = !en ? 0 : (sum > 8191) ? 8191 : (sum < -8192) ? -8192 : sum;
                n_clip[c] = (cfg_update ? 1'b0 : m_clip[c]) | sat;
                if (sync_reset || !en || (cfg_update && cfg_mode[c*4+3] && !en))
                    n_ph[c] = 0;
                else
                    n_ph[c] = m_ph[c] + m_inc[c];
                if (cfg_update) begin
                    n_inc[c]  = phase_inc[c*PW +: PW];
                    n_amp[c]  = int'(amplitude[c*AW +: AW]);
                    n_off[c]  = int'($signed(offset[c*DW +: DW]));
                    n_mode[c] = cfg_mode[c*4 +: 4];
                end else begin
                    n_inc[c] = m_inc[c]; n_amp[c] = m_amp[c]; n_off[c] = m_off[c]; n_mode[c] = m_mode[c];
                end
            end
        end
        n_vcnt = !aresetn ? 0 : (m_vcnt < 3 ? m_vcnt + 1 : 3);
        @(posedge clk);
        #1;
        for (int c = 0; c < NC; c++) begin
            m_inc[c] = n_inc[c]; m_amp[c] = n_amp[c]; m_off[c] = n_off[c]; m_mode[c] = n_mode[c];
            m_ph[c] = n_ph[c]; m_hold[c] = n_hold[c]; m_r1[c] = n_r1[c]; m_s2[c] = n_s2[c];
            m_o3[c] = n_o3[c]; m_clip[c] = n_clip[c];
        end
        m_vcnt = n_vcnt;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        repeat (5) tick();
        n_vec++;
        if (m_axis_tdata !== '0) begin n_err++; $display("FAIL reset_tdata: got %h want 0", m_axis_tdata); end
        n_vec++;
        if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL reset_tvalid: got %b want 0", m_axis_tvalid); end
        n_vec++;
        if (clip !== '0) begin n_err++; $display("FAIL reset_clip: got %b want 0", clip); end
        aresetn = 1'b1;
        for (int j = 1; j <= 4; j++) begin
            tick();
            n_vec++;
            if (m_axis_tvalid !== (j >= 3)) begin
                n_err++; $display("FAIL tvalid_rise edge %0d: got %b want %b", j, m_axis_tvalid, (j >= 3));
            end
        end
    endtask

    task automatic test_dc();
        set_lane(0, 32'd0, 16'd65535, 14'd0, 4'b1001);
        set_lane(1, 32'd0, 16'd0, 14'd0, 4'b0000);
        cfg_update = 1'b1; tick(); cfg_update = 1'b0;
        repeat (5) tick();
        n_vec++;
        if (lane_out(0) !== 8191) begin n_err++; $display("FAIL dc_steady: got %0d want 8191", lane_out(0)); end
        n_vec++;
        if (clip[0] !== 1'b0) begin n_err++; $display("FAIL dc_noclip: got %b want 0", clip[0]); end
        set_lane(0, 32'd0, 16'd65535, 14'd100, 4'b1001);
        cfg_update = 1'b1; tick(); cfg_update = 1'b0;
        repeat (4) tick();
        n_vec++;
        if (lane_out(0) !== 8191) begin n_err++; $display("FAIL dc_sat: got %0d want 8191", lane_out(0)); end
        n_vec++;
        if (clip[0] !== 1'b1) begin n_err++; $display("FAIL dc_clip_set: got %b want 1", clip[0]); end
        set_lane(0, 32'd0, 16'd65535, 14'd0, 4'b1001);
        cfg_update = 1'b1; tick(); cfg_update = 1'b0;
        // The update edge still saturates with the old offset, so set wins here.
        n_vec++;
        if (clip[0] !== m_clip[0]) begin n_err++; $display("FAIL dc_clip_setwins: got %b want %b", clip[0], m_clip[0]); end
        repeat (4) tick();
        cfg_update = 1'b1; tick(); cfg_update = 1'b0;
        n_vec++;
        if (clip[0] !== 1'b0) begin n_err++; $display("FAIL dc_clip_clear: got %b want 0", clip[0]); end
        n_vec++;
        if (lane_out(0) !== 8191) begin n_err++; $display("FAIL dc_after_clear: got %0d want 8191", lane_out(0)); end
    endtask

    task automatic test_square();
        int exp;
        set_lane(0, 32'd0, 16'd0, 14'd0, 4'b0000);
        set_lane(1, 32'h1000_0000, 16'd32768, 14'd0, 4'b1010);
        cfg_update = 1'b1; tick(); cfg_update = 1'b0;
        for (int j = 1; j <= 40; j++) begin
            tick();
            n_vec++;
            if (lane_out(0) !== 0) begin n_err++; $display("FAIL sq_lane0 j%0d: got %0d want 0", j, lane_out(0)); end
            if (j >= 3) begin
                exp = (((j - 3) % 16) < 8) ? 4095 : -4096;
                n_vec++;
                if (lane_out(1) !== exp) begin n_err++; $display("FAIL sq_lane1 j%0d: got %0d want %0d", j, lane_out(1), exp); end
            end
        end
    endtask

    task automatic test_saw_tri();
        int exp, idx, u, raw;
        set_lane(0, 32'h1000_0000, 16'd65535, 14'd0, 4'b1100);
        cfg_update = 1'b1; sync_reset = 1'b1; tick(); cfg_update = 1'b0; sync_reset = 1'b0;
        for (int j = 1; j <= 34; j++) begin
            tick();
            if (j >= 3) begin
                idx = (j - 3) % 16;
                exp = scale_of(idx * 4096 - 32768, 65535);
                n_vec++;
                if (lane_out(0) !== exp) begin n_err++; $display("FAIL saw j%0d: got %0d want %0d", j, lane_out(0), exp); end
            end
            n_vec++;
            if (lane_out(1) !== m_o3[1]) begin n_err++; $display("FAIL saw_lane1 j%0d: got %0d want %0d", j, lane_out(1), m_o3[1]); end
        end
        set_lane(0, 32'h1000_0000, 16'd65535, 14'd0, 4'b1011);
        cfg_update = 1'b1; sync_reset = 1'b1; tick(); cfg_update = 1'b0; sync_reset = 1'b0;
        for (int j = 1; j <= 34; j++) begin
            tick();
            if (j >= 3) begin
                idx = (j - 3) % 16;
                u   = (idx % 8) * 8192;
                raw = (idx >= 8) ? (32767 - u) : (u - 32768);
                exp = scale_of(raw, 65535);
                n_vec++;
                if (lane_out(0) !== exp) begin n_err++; $display("FAIL tri j%0d: got %0d want %0d", j, lane_out(0), exp); end
            end
        end
    endtask

    task automatic test_shadow_sync();
        int hist[16];
        int exp;
        for (int i = 0; i < 16; i++) begin tick(); hist[i] = lane_out(0); end
        set_lane(0, 32'h0800_0000, 16'd65535, 14'd0, 4'b1011);
        for (int i = 0; i < 16; i++) begin
            tick();
            n_vec++;
            if (lane_out(0) !== hist[i]) begin n_err++; $display("FAIL shadow_hold i%0d: got %0d want %0d", i, lane_out(0), hist[i]); end
        end
        cfg_update = 1'b1; sync_reset = 1'b1; tick(); cfg_update = 1'b0; sync_reset = 1'b0;
        for (int j = 1; j <= 8; j++) begin
            tick();
            n_vec++;
            if (lane_out(0) !== m_o3[0]) begin n_err++; $display("FAIL sync_model j%0d: got %0d want %0d", j, lane_out(0), m_o3[0]); end
            if (j >= 3) begin
                exp = scale_of(raw_of(3, 32'(j - 3) << 27, 0), 65535);
                n_vec++;
                if (lane_out(0) !== exp) begin n_err++; $display("FAIL sync_restart j%0d: got %0d want %0d", j, lane_out(0), exp); end
            end
        end
    endtask

    task automatic test_sine();
        set_lane(0, 32'd0, 16'd65535, 14'd0, 4'b1000);
        s_data[15:0] = 16'd1000; s_valid[0] = 1'b1;
        cfg_update = 1'b1; tick(); cfg_update = 1'b0;
        repeat (4) tick();
        s_data[15:0] = 16'd5000; s_valid[0] = 1'b0;
        for (int j = 1; j <= 8; j++) begin
            tick();
            if (j >= 4) begin
                n_vec++;
                if (lane_out(0) !== 249) begin n_err++; $display("FAIL sine_hold j%0d: got %0d want 249", j, lane_out(0)); end
            end
        end
        set_lane(0, 32'd0, 16'd65535, 14'd50, 4'b1110);
        cfg_update = 1'b1; tick(); cfg_update = 1'b0;
        repeat (4) tick();
        n_vec++;
        if (lane_out(0) !== 50) begin n_err++; $display("FAIL zero_type_offset: got %0d want 50", lane_out(0)); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            s_valid = NC'($urandom);
            s_data  = (NC*SW)'($urandom);
            for (int c = 0; c < NC; c++)
                set_lane(c, ($urandom % 2 == 0) ? $urandom : (32'd1 << $urandom_range(20, 31)),
                         16'($urandom), 14'($urandom), 4'($urandom));
            cfg_update = (($urandom % 12) == 0);
            sync_reset = (($urandom % 24) == 0);
            aresetn    = (($urandom % 150) != 0);
            tick();
            for (int c = 0; c < NC; c++) begin
                n_vec++;
                if (lane_out(c) !== m_o3[c]) begin n_err++; $display("FAIL rand_lane%0d i%0d: got %0d want %0d", c, i, lane_out(c), m_o3[c]); end
                n_vec++;
                if (clip[c] !== m_clip[c]) begin n_err++; $display("FAIL rand_clip%0d i%0d: got %b want %b", c, i, clip[c], m_clip[c]); end
            end
            n_vec++;
            if (m_axis_tvalid !== (m_vcnt == 3)) begin n_err++; $display("FAIL rand_tvalid i%0d: got %b want %b", i, m_axis_tvalid, (m_vcnt == 3)); end
        end
        aresetn = 1'b1; cfg_update = 1'b0; sync_reset = 1'b0;
    endtask

    initial begin
        aresetn = 1'b0; s_data = '0; s_valid = '0; phase_inc = '0; amplitude = '0;
        offset = '0; cfg_mode = '0; cfg_update = 1'b0; sync_reset = 1'b0;
        for (int c = 0; c < NC; c++) begin
            m_inc[c] = 0; m_amp[c] = 0; m_off[c] = 0; m_mode[c] = 0; m_ph[c] = 0;
            m_hold[c] = 0; m_r1[c] = 0; m_s2[c] = 0; m_o3[c] = 0; m_clip[c] = 0;
        end
        m_vcnt = 0;
        test_reset();
        test_dc();
        test_square();
        test_saw_tri();
        test_shadow_sync();
        test_sine();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
